// File: rtl/riscv_pkg.sv
// Shared definitions for the EX stage: ALU op codes, MUL FSM states and
// the operand forwarding selector.
package riscv_pkg;

  localparam int RV_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_MUL   = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // EX/MEM result wins over MEM/WB data; x0 never forwards.
  function automatic logic [RV_XLEN-1:0] fwd_select(
    input logic               wb_3,
    input logic [4:0]         rd_3,
    input logic               wb_4,
    input logic [4:0]         rd_4,
    input logic [4:0]         rs,
    input logic [RV_XLEN-1:0] reg_val,
    input logic [RV_XLEN-1:0] fwd_4,
    input logic [RV_XLEN-1:0] wb_5
  );
    if (wb_3 && (rd_3 != 5'd0) && (rd_3 == rs)) begin
      return fwd_4;
    end else if (wb_4 && (rd_4 != 5'd0) && (rd_4 == rs)) begin
      return wb_5;
    end else begin
      return reg_val;
    end
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Bundle of decode-side inputs, forwarding sources and EX/MEM outputs
// around the execute stage. master = surrounding pipeline, slave = EX.
interface execute_stage_if;
  import riscv_pkg::*;

  logic               memory_stall;
  logic               valid_2;
  logic [RV_XLEN-1:0] rs1_data_2;
  logic [RV_XLEN-1:0] rs2_data_2;
  logic [RV_XLEN-1:0] imm_2;
  logic [4:0]         Rs1_2;
  logic [4:0]         Rs2_2;
  logic [4:0]         Rd_2;
  logic [3:0]         ALUctrl_2;
  logic               ALUSrc_2;
  logic               WriteBack_2;
  logic [1:0]         Mem_2;
  logic [RV_XLEN-1:0] forward_result_4;
  logic [RV_XLEN-1:0] wb_data_5;
  logic [4:0]         Rd_4;
  logic               WriteBack_4;
  logic [RV_XLEN-1:0] ALU_result_3;
  logic [RV_XLEN-1:0] writedata_3;
  logic               WriteBack_3;
  logic [1:0]         Mem_3;
  logic [4:0]         Rd_3;
  logic               ex_busy;

  modport master (
    output memory_stall, valid_2, rs1_data_2, rs2_data_2, imm_2,
           Rs1_2, Rs2_2, Rd_2, ALUctrl_2, ALUSrc_2, WriteBack_2, Mem_2,
           forward_result_4, wb_data_5, Rd_4, WriteBack_4,
    input  ALU_result_3, writedata_3, WriteBack_3, Mem_3, Rd_3, ex_busy
  );

  modport slave (
    input  memory_stall, valid_2, rs1_data_2, rs2_data_2, imm_2,
           Rs1_2, Rs2_2, Rd_2, ALUctrl_2, ALUSrc_2, WriteBack_2, Mem_2,
           forward_result_4, wb_data_5, Rd_4, WriteBack_4,
    output ALU_result_3, writedata_3, WriteBack_3, Mem_3, Rd_3, ex_busy
  );

endinterface

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier, one partial product per cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   MUL_IDLE | waiting; start latches operands and asserts busy
//   MUL_BUSY | one shift-add step per cycle, stall does not pause it
//   MUL_DONE | product valid; leaves once the memory stage accepts it
module iter_multiplier
  import riscv_pkg::*;
#(
  parameter int XLEN      = RV_XLEN,
  parameter int MUL_STEPS = RV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_stall_in,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_product
);

  localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

  mul_state_t       r_state;
  mul_state_t       w_state_nxt;
  logic [XLEN-1:0]  r_mcand;
  logic [XLEN-1:0]  r_mplier;
  logic [XLEN-1:0]  r_acc;
  logic [CNT_W-1:0] r_cnt;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MUL_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state: the last step is the one taken with the counter at zero
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MUL_IDLE: if (i_start)       w_state_nxt = MUL_BUSY;
      MUL_BUSY: if (r_cnt == '0)   w_state_nxt = MUL_DONE;
      MUL_DONE: if (!i_stall_in)   w_state_nxt = MUL_IDLE;
      default:                     w_state_nxt = MUL_IDLE;
    endcase
  end

  // outputs: busy covers the issue cycle so upstream holds the MUL at once
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      MUL_IDLE: o_busy = i_start;
      MUL_BUSY: o_busy = 1'b1;
      MUL_DONE: o_done = 1'b1;
      default:  o_busy = 1'b0;
    endcase
  end

  // shift-add datapath with terminal-count down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if ((r_state == MUL_IDLE) && i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= CNT_W'(MUL_STEPS - 1);
    end else if (r_state == MUL_BUSY) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_product = r_acc;

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, combinational ALU, iterative MUL and the
// EX/MEM pipeline register.
module execute_stage
  import riscv_pkg::*;
#(
  parameter int XLEN      = RV_XLEN,
  parameter int MUL_STEPS = RV_XLEN
) (
  input logic            clk,
  input logic            rst_n,
  execute_stage_if.slave ex
);

  alu_op_t         w_op;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b_raw;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_product;
  logic            w_mul_start;
  logic            w_busy;
  logic            w_mul_done;

  assign w_op = alu_op_t'(ex.ALUctrl_2);

  // forwarded operands; writedata always takes the unmuxed rs2 path
  always_comb begin
    w_a = fwd_select(ex.WriteBack_3, ex.Rd_3, ex.WriteBack_4, ex.Rd_4,
                     ex.Rs1_2, ex.rs1_data_2, ex.forward_result_4,
                     ex.wb_data_5);
    w_b_raw = fwd_select(ex.WriteBack_3, ex.Rd_3, ex.WriteBack_4, ex.Rd_4,
                         ex.Rs2_2, ex.rs2_data_2, ex.forward_result_4,
                         ex.wb_data_5);
    w_b = ex.ALUSrc_2 ? ex.imm_2 : w_b_raw;
  end

  assign w_mul_start = ex.valid_2 && (w_op == ALU_MUL) && !ex.memory_stall;

  iter_multiplier #(
    .XLEN      (XLEN),
    .MUL_STEPS (MUL_STEPS)
  ) u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_mul_start),
    .i_a        (w_a),
    .i_b        (w_b),
    .i_stall_in (ex.memory_stall),
    .o_busy     (w_busy),
    .o_done     (w_mul_done),
    .o_product  (w_product)
  );

  assign ex.ex_busy = w_busy;

  // single-cycle ALU; MUL only yields a value once the multiplier is done
  always_comb begin
    w_alu = '0;
    case (w_op)
      ALU_ADD:   w_alu = w_a + w_b;
      ALU_SUB:   w_alu = w_a - w_b;
      ALU_AND:   w_alu = w_a & w_b;
      ALU_OR:    w_alu = w_a | w_b;
      ALU_XOR:   w_alu = w_a ^ w_b;
      ALU_SLL:   w_alu = w_a << w_b[4:0];
      ALU_SRL:   w_alu = w_a >> w_b[4:0];
      ALU_SRA:   w_alu = $signed(w_a) >>> w_b[4:0];
      ALU_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      ALU_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (w_a < w_b)};
      ALU_PASSB: w_alu = w_b;
      ALU_MUL:   w_alu = w_mul_done ? w_product : '0;
      default:   w_alu = '0;
    endcase
  end

  // EX/MEM register: stall holds everything, busy or invalid loads a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex.ALU_result_3 <= '0;
      ex.writedata_3  <= '0;
      ex.WriteBack_3  <= 1'b0;
      ex.Mem_3        <= 2'b00;
      ex.Rd_3         <= 5'd0;
    end else if (!ex.memory_stall) begin
      if (w_busy || !ex.valid_2) begin
        ex.WriteBack_3 <= 1'b0;
        ex.Mem_3       <= 2'b00;
        ex.Rd_3        <= 5'd0;
      end else begin
        ex.ALU_result_3 <= w_alu;
        ex.writedata_3  <= w_b_raw;
        ex.WriteBack_3  <= ex.WriteBack_2;
        ex.Mem_3        <= ex.Mem_2;
        ex.Rd_3         <= ex.Rd_2;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  execute_stage_if bus();

  execute_stage dut (.clk(clk), .rst_n(rst_n), .ex(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected EX/MEM contents for the random test
  logic [31:0] m_res, m_wd;
  logic        m_wb;
  logic [1:0]  m_mem;
  logic [4:0]  m_rd;

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] t;
    int          sa, sb;
    sa = a;
    sb = b;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return a << b[4:0];
      6:  return a >> b[4:0];
      7:  begin t = {{32{a[31]}}, a} >> b[4:0]; return t[31:0]; end
      8:  return (sa < sb) ? 32'd1 : 32'd0;
      9:  return (a < b) ? 32'd1 : 32'd0;
      10: return b;
      11: begin t = 64'(a) * 64'(b); return t[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] regv);
    if (m_wb && m_rd != 0 && m_rd == rs) return bus.forward_result_4;
    if (bus.WriteBack_4 && bus.Rd_4 != 0 && bus.Rd_4 == rs) return bus.wb_data_5;
    return regv;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] rs1v, input logic [31:0] rs2v,
                       input logic [31:0] imm, input logic alusrc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic wb,
                       input logic [1:0] mem);
    bus.valid_2     = 1'b1;
    bus.ALUctrl_2   = op;
    bus.rs1_data_2  = rs1v;
    bus.rs2_data_2  = rs2v;
    bus.imm_2       = imm;
    bus.ALUSrc_2    = alusrc;
    bus.Rs1_2       = rs1;
    bus.Rs2_2       = rs2;
    bus.Rd_2        = rd;
    bus.WriteBack_2 = wb;
    bus.Mem_2       = mem;
  endtask

  task automatic set_fwd(input logic [31:0] f4, input logic [31:0] w5, input logic [4:0] rd4, input logic wb4);
    bus.forward_result_4 = f4;
    bus.wb_data_5        = w5;
    bus.Rd_4             = rd4;
    bus.WriteBack_4      = wb4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.memory_stall = 1'b0;
    set_fwd(32'h1234, 32'h5678, 5'd3, 1'b1);
    drive(4'd0, 32'hAAAA, 32'h5555, 32'h1, 1'b0, 5'd1, 5'd2, 5'd4, 1'b1, 2'b10);
    repeat (3) tick();
    n_tests++;
    if (bus.ALU_result_3 !== 0 || bus.writedata_3 !== 0 || bus.WriteBack_3 !== 0 ||
        bus.Mem_3 !== 0 || bus.Rd_3 !== 0 || bus.ex_busy !== 0) begin
      n_fail++;
      $display("FAIL reset: got res=%h wd=%h wb=%b mem=%b rd=%0d busy=%b, want all 0",
               bus.ALU_result_3, bus.writedata_3, bus.WriteBack_3, bus.Mem_3, bus.Rd_3, bus.ex_busy);
    end
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forwarding();
    set_fwd(32'h0, 32'h0, 5'd0, 1'b0);
    drive(4'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 2'b00);
    tick();
    set_fwd(32'h10, 32'h20, 5'd5, 1'b1);
    drive(4'd0, 32'h999, 32'h0, 32'h1, 1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 2'b00);
    tick();
    n_tests++;
    if (bus.ALU_result_3 !== 32'h11) begin
      n_fail++;
      $display("FAIL fwd_priority: got %h, want 00000011", bus.ALU_result_3);
    end
    // Rd_3 is now 6, so x5 must come from the write-back path
    tick();
    n_tests++;
    if (bus.ALU_result_3 !== 32'h21) begin
      n_fail++;
      $display("FAIL fwd_wb5: got %h, want 00000021", bus.ALU_result_3);
    end
    // rs2 forwarding feeds writedata while B takes the immediate
    set_fwd(32'hCAFE0000, 32'h20, 5'd0, 1'b0);
    drive(4'd0, 32'h3, 32'h77, 32'h100, 1'b1, 5'd1, 5'd6, 5'd10, 1'b1, 2'b01);
    tick();
    n_tests++;
    if (bus.ALU_result_3 !== 32'h103 || bus.writedata_3 !== 32'hCAFE0000 || bus.Mem_3 !== 2'b01) begin
      n_fail++;
      $display("FAIL fwd_rs2: got res=%h wd=%h mem=%b, want 00000103 cafe0000 01",
               bus.ALU_result_3, bus.writedata_3, bus.Mem_3);
    end
  endtask

  task automatic test_x0_guard();
    set_fwd(32'h0, 32'h0, 5'd0, 1'b0);
    drive(4'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 2'b00);
    tick();
    set_fwd(32'hDEAD, 32'hBEEF, 5'd0, 1'b1);
    drive(4'd0, 32'h0, 32'h0, 32'h123, 1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 2'b00);
    tick();
    n_tests++;
    if (bus.ALU_result_3 !== 32'h123) begin
      n_fail++;
      $display("FAIL x0_guard: got %h, want 00000123", bus.ALU_result_3);
    end
  endtask

  task automatic test_shift_compare();
    set_fwd(32'h0, 32'h0, 5'd0, 1'b0);
    drive(4'd7, 32'h80000000, 32'h0, 32'h4, 1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 2'b00);
    tick();
    n_tests++;
    if (bus.ALU_result_3 !== 32'hF8000000) begin
      n_fail++;
      $display("FAIL sra: got %h, want f8000000", bus.ALU_result_3);
    end
    drive(4'd9, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 5'd1, 5'd2, 5'd10, 1'b1, 2'b00);
    tick();
    n_tests++;
    if (bus.ALU_result_3 !== 32'h1) begin
      n_fail++;
      $display("FAIL sltu: got %h, want 00000001", bus.ALU_result_3);
    end
    drive(4'd8, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 5'd1, 5'd2, 5'd10, 1'b1, 2'b00);
    tick();
    n_tests++;
    if (bus.ALU_result_3 !== 32'h0) begin
      n_fail++;
      $display("FAIL slt: got %h, want 00000000", bus.ALU_result_3);
    end
  endtask

  task automatic test_stall_hold();
    set_fwd(32'h0, 32'h0, 5'd0, 1'b0);
    drive(4'd0, 32'h1000, 32'h0, 32'h20, 1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 2'b10);
    tick();
    bus.memory_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4'($urandom_range(0, 10)), $urandom, $urandom, $urandom, 1'b0, 5'd1, 5'd2,
            5'd12 + 5'(i), 1'b1, 2'b01);
      tick();
      n_tests++;
      if (bus.ALU_result_3 !== 32'h1020 || bus.Rd_3 !== 5'd7 || bus.WriteBack_3 !== 1'b1 ||
          bus.Mem_3 !== 2'b10) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got res=%h rd=%0d wb=%b mem=%b, want 00001020 7 1 10",
                 i, bus.ALU_result_3, bus.Rd_3, bus.WriteBack_3, bus.Mem_3);
      end
    end
    drive(4'd4, 32'hF0, 32'h0, 32'h0F, 1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 2'b00);
    bus.memory_stall = 1'b0;
    tick();
    n_tests++;
    if (bus.ALU_result_3 !== 32'hFF || bus.Rd_3 !== 5'd8) begin
      n_fail++;
      $display("FAIL stall_release: got res=%h rd=%0d, want 000000ff 8", bus.ALU_result_3, bus.Rd_3);
    end
  endtask

  // Issues a MUL, counts ex_busy cycles, optionally stalls in DONE, then
  // checks the product. Returns at the cycle after the product loaded.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input int hold, input string tag);
    int          busy_cnt;
    bit          bubble_bad;
    logic [31:0] exp_p;
    exp_p = ref_alu(11, a, b);
    set_fwd(32'h0, 32'h0, 5'd0, 1'b0);
    drive(4'd11, a, b, 32'h0, 1'b0, 5'd1, 5'd2, rd, 1'b1, 2'b00);
    #1;
    busy_cnt   = bus.ex_busy ? 1 : 0;
    bubble_bad = 1'b0;
    for (int k = 0; k < 60 && bus.ex_busy; k++) begin
      tick();
      if (bus.WriteBack_3 !== 1'b0 || bus.Mem_3 !== 2'b00 || bus.Rd_3 !== 5'd0) bubble_bad = 1'b1;
      if (bus.ex_busy) busy_cnt++;
    end
    n_tests++;
    if (busy_cnt != 33 || bubble_bad) begin
      n_fail++;
      $display("FAIL %s_busy: got busy_cycles=%0d bubble_bad=%b, want 33 0", tag, busy_cnt, bubble_bad);
    end
    if (hold > 0) begin
      bus.memory_stall = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        n_tests++;
        if (bus.WriteBack_3 !== 1'b0 || bus.ex_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_done_stall[%0d]: got wb=%b busy=%b, want 0 0", tag, i, bus.WriteBack_3, bus.ex_busy);
        end
      end
      bus.memory_stall = 1'b0;
    end
    tick();
    n_tests++;
    if (bus.ALU_result_3 !== exp_p || bus.Rd_3 !== rd || bus.WriteBack_3 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_product: got res=%h rd=%0d wb=%b, want %h %0d 1",
               tag, bus.ALU_result_3, bus.Rd_3, bus.WriteBack_3, exp_p, rd);
    end
  endtask

  task automatic test_mul();
    do_mul(32'd7, 32'hFFFFFFFD, 5'd9, 0, "mul");
    n_tests++;
    if (bus.ALU_result_3 !== 32'hFFFFFFEB) begin
      n_fail++;
      $display("FAIL mul_const: got %h, want ffffffeb", bus.ALU_result_3);
    end
  endtask

  task automatic test_back_to_back();
    do_mul($urandom, $urandom, 5'd11, 0, "b2b_first");
    do_mul($urandom, $urandom, 5'd13, 0, "b2b_second");
    do_mul($urandom, $urandom, 5'd14, 3, "mul_done_stall");
    bus.valid_2 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_mul();
    do_mul(32'd3, 32'd5, 5'd9, 0, "pre_reset");
    drive(4'd11, 32'h1234, 32'h5678, 32'h0, 1'b0, 5'd1, 5'd2, 5'd15, 1'b1, 2'b00);
    repeat (11) tick();
    rst_n = 1'b0;
    bus.valid_2 = 1'b0;
    #1;
    n_tests++;
    if (bus.ALU_result_3 !== 0 || bus.writedata_3 !== 0 || bus.WriteBack_3 !== 0 ||
        bus.Mem_3 !== 0 || bus.Rd_3 !== 0 || bus.ex_busy !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_mul: got res=%h wd=%h wb=%b mem=%b rd=%0d busy=%b, want all 0",
               bus.ALU_result_3, bus.writedata_3, bus.WriteBack_3, bus.Mem_3, bus.Rd_3, bus.ex_busy);
    end
    #5 rst_n = 1'b1;
    set_fwd(32'h0, 32'h0, 5'd0, 1'b0);
    drive(4'd0, 32'd2, 32'd3, 32'h0, 1'b0, 5'd1, 5'd2, 5'd4, 1'b1, 2'b00);
    tick();
    n_tests++;
    if (bus.ALU_result_3 !== 32'd5 || bus.Rd_3 !== 5'd4 || bus.WriteBack_3 !== 1'b1) begin
      n_fail++;
      $display("FAIL add_after_reset: got res=%h rd=%0d wb=%b, want 00000005 4 1",
               bus.ALU_result_3, bus.Rd_3, bus.WriteBack_3);
    end
  endtask

  task automatic test_random_alu();
    logic [31:0] a, b_raw, b;
    rst_n = 1'b0;
    bus.valid_2 = 1'b0;
    #2 rst_n = 1'b1;
    m_res = '0; m_wd = '0; m_wb = 1'b0; m_mem = 2'b00; m_rd = 5'd0;
    for (int i = 0; i < 300; i++) begin
      set_fwd($urandom, $urandom, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      drive(4'($urandom_range(0, 10)), $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      bus.valid_2      = ($urandom_range(0, 9) != 0);
      bus.memory_stall = ($urandom_range(0, 4) == 0);
      if (!bus.memory_stall) begin
        if (!bus.valid_2) begin
          m_wb = 1'b0; m_mem = 2'b00; m_rd = 5'd0;
        end else begin
          a     = ref_fwd(bus.Rs1_2, bus.rs1_data_2);
          b_raw = ref_fwd(bus.Rs2_2, bus.rs2_data_2);
          b     = bus.ALUSrc_2 ? bus.imm_2 : b_raw;
          m_res = ref_alu(int'(bus.ALUctrl_2), a, b);
          m_wd  = b_raw;
          m_wb  = bus.WriteBack_2;
          m_mem = bus.Mem_2;
          m_rd  = bus.Rd_2;
        end
      end
      tick();
      n_tests++;
      if (bus.ALU_result_3 !== m_res || bus.writedata_3 !== m_wd || bus.WriteBack_3 !== m_wb ||
          bus.Mem_3 !== m_mem || bus.Rd_3 !== m_rd || bus.ex_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d]: got res=%h wd=%h wb=%b mem=%b rd=%0d busy=%b, want %h %h %b %b %0d 0",
                 i, bus.ALU_result_3, bus.writedata_3, bus.WriteBack_3, bus.Mem_3, bus.Rd_3,
                 bus.ex_busy, m_res, m_wd, m_wb, m_mem, m_rd);
      end
    end
    bus.memory_stall = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_forwarding();
    test_x0_guard();
    test_shift_compare();
    test_stall_hold();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_random_alu();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
